fetch_stage_1: RTL
==================

Name: fetch_stage_1

Overview:
First fetch stage. Owns the PC and the instruction-memory request handshake, and presents raw 32-bit words to fetch_stage_2. It classifies each instruction as compressed, aligned 32-bit, or 32-bit split across a word boundary. It reuses a buffered word when consecutive compressed instructions share that word. Redirects from execute (branch/jump/trap) kill in-flight requests and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bit 0 must be 0.
MEM_TIMEOUT, 0, cycles to wait for imem_rvalid before raising fetch_err; 0 disables the timeout.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
imem_req  out  1  request strobe, one cycle per request
imem_addr  out  32  word-aligned request address, bits [1:0] = 0
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data word
stall_if  in  1  downstream not accepting; hold outputs
redirect  in  1  take redirect_pc this cycle
redirect_pc  in  32  target PC; bit 0 ignored
fetch1_instruction  out  32  raw memory word for fetch_stage_2
fetch1_pc  out  32  PC of the instruction being presented
fetch1_valid  out  1  outputs hold a usable beat
is_compressed  out  1  instruction at fetch1_pc is 16-bit
is_second_half_needed  out  1  32-bit instruction starts at pc[1]=1; next beat carries the upper half
pc_word_aligned  out  1  fetch1_pc[1] == 0
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset: pc=RESET_PC; state=REQ; all outputs 0 except imem_addr={RESET_PC[31:2],2'b00}; buffered-word valid=0; kill=0.
- States:
  - REQ: imem_req=1, addr={pc[31:2],00}. On imem_gnt -> WAIT.
  - WAIT: on imem_rvalid, capture rdata into buf and set buf_valid, then classify.
  - SPLIT_REQ / SPLIT_WAIT: fetch word pc+2 (the next word) for the upper half of a split instruction.
  - HOLD: output beat presented while stall_if=1.
- Classification: half = pc[1] ? buf[17:16] : buf[1:0].
  - Compressed iff half != 2'b11.
  - Compressed: present word; next pc=pc+2.
  - pc[1]=0 and not compressed: aligned 32-bit; next pc=pc+4.
  - pc[1]=1 and not compressed: split. Present the first word with is_second_half_needed=1, then present the next word with is_second_half_needed=0, is_compressed=0, and fetch1_pc held at the original pc. Next pc=pc+4.
- Word reuse: if the next pc lies in the same word as buf (pc[31:2] unchanged) and buf_valid=1, present from buf the next cycle with no memory request.
- Output timing: one beat per accepted cycle.
  - fetch1_* are registered and valid the cycle after rvalid (or after reuse).
  - While stall_if=1, every fetch1_* output is held stable and pc does not advance.
  - One request is outstanding at most.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:1],0}; fetch1_valid <= 0; buf_valid <= 0; state <= REQ next cycle.
  - If a request is outstanding (WAIT/SPLIT_WAIT), set kill. The next imem_rvalid is discarded and clears kill; REQ for the new pc is issued only after that.
  - Redirect and imem_rvalid in the same cycle: the data is discarded and no kill is needed.
- Redirect during a split: the second half is never presented.
- Timeout (MEM_TIMEOUT>0): a counter runs in WAIT/SPLIT_WAIT. On reaching MEM_TIMEOUT, fetch_err is set (sticky until reset) and the state stays in WAIT.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFE+2 wraps to 0.
- Reset asserted mid-transaction: immediate return to reset values. A late rvalid after reset release is ignored only if kill was set, so memory must also be reset.

Decomposition:
- fetch_pkg: state enum (REQ, WAIT, SPLIT_REQ, SPLIT_WAIT, HOLD), function is_rvc(logic[1:0]), constant ILEN=32.
- One sub-module: fetch_timeout_ctr (counter, enable, clear, expired flag).
- All other logic stays in this module.

Test Plan:
- Reset RESET_PC=0x100; word 0x00000013 at 0x100 -> imem_addr=0x100; beat pc=0x100, compressed=0, aligned=1; next request 0x104.
- Word 0x4501_4505 at 0x200 (two c.li) -> beats pc=0x200 then pc=0x202, both compressed=1; only one imem_req.
- Word 0x0013_4505 at 0x300 followed by 0x0000_0000 at 0x304 -> beat pc=0x300 compressed; beat pc=0x302 second_half_needed=1; beat pc=0x302 from the word at 0x304; next pc=0x306.
- Redirect to 0x400 while in WAIT for 0x104 -> 0x104 data dropped, no beat; next imem_addr=0x400; first beat pc=0x400.
- stall_if held 3 cycles with a beat present -> fetch1_* stable for 3 cycles, no new imem_req.
- MEM_TIMEOUT=8, no rvalid -> fetch_err=1 at the 8th WAIT cycle; remains 1 after a later rvalid.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch front end.
package fetch_pkg;
  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    SPLIT_REQ,
    SPLIT_WAIT,
    HOLD
  } fetch_state_t;

  // RVC encodings use every low-half pattern except 2'b11.
  function automatic logic is_rvc(input logic [1:0] half);
    return half != 2'b11;
  endfunction
endpackage

// File: rtl/fetch_timeout_ctr.sv
// Down-counter that flags a memory response overdue after LIMIT enabled cycles.
module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [15:0] LOAD = (LIMIT > 0) ? 16'(LIMIT - 1) : 16'd0;

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= LOAD;
    else if (clear) cnt_q <= LOAD;
    else if (enable && cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
  end

  // Terminal count reached on the LIMIT-th enabled cycle; saturates there.
  assign expired = (LIMIT != 0) && enable && (cnt_q == 16'd0);
endmodule

// File: rtl/fetch_stage_1.sv
// First fetch stage: PC ownership, imem handshake, RVC/split classification.
// state      | meaning
// REQ        | request word at pc (held off while a killed response is pending)
// WAIT       | waiting for the word at pc
// SPLIT_REQ  | request the word holding the upper half of a split instruction
// SPLIT_WAIT | waiting for that upper-half word
// HOLD       | beat presented; reuse buffered word or move on when not stalled
module fetch_stage_1
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall_if,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  output logic [ILEN-1:0] fetch1_instruction,
  output logic [31:0]     fetch1_pc,
  output logic            fetch1_valid,
  output logic            is_compressed,
  output logic            is_second_half_needed,
  output logic            pc_word_aligned,
  output logic            fetch_err
);
  fetch_state_t    state_q, state_n;
  logic [31:0]     pc_q, pc_n;
  logic [ILEN-1:0] buf_q, buf_n;
  logic [29:0]     buf_word_q, buf_word_n;
  logic            buf_valid_q, buf_valid_n;
  logic            split_q, split_n;
  logic            kill_q, kill_n;
  logic            run_q;
  logic [ILEN-1:0] f1_instr_q, f1_instr_n;
  logic [31:0]     f1_pc_q, f1_pc_n;
  logic            f1_valid_q, f1_valid_n;
  logic            f1_comp_q, f1_comp_n;
  logic            f1_sec_q, f1_sec_n;
  logic            err_q;

  logic            in_wait, tmo_expired, present_cls, comp;
  logic [31:0]     word_base;
  logic [ILEN-1:0] src_word;
  logic [1:0]      half;

  assign in_wait   = (state_q == WAIT) || (state_q == SPLIT_WAIT);
  assign word_base = {pc_q[31:2], 2'b00};
  assign imem_addr = (state_q == SPLIT_REQ || state_q == SPLIT_WAIT) ? word_base + 32'd4 : word_base;
  assign imem_req  = run_q && !kill_q && (state_q == REQ || state_q == SPLIT_REQ);

  assign src_word  = (state_q == HOLD) ? buf_q : imem_rdata;
  assign half      = pc_q[1] ? src_word[17:16] : src_word[1:0];
  assign comp      = is_rvc(half);

  fetch_timeout_ctr #(.LIMIT(MEM_TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (tmo_expired)
  );

  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    buf_n       = buf_q;
    buf_word_n  = buf_word_q;
    buf_valid_n = buf_valid_q;
    split_n     = split_q;
    kill_n      = kill_q && !imem_rvalid;
    f1_instr_n  = f1_instr_q;
    f1_pc_n     = f1_pc_q;
    f1_valid_n  = f1_valid_q;
    f1_comp_n   = f1_comp_q;
    f1_sec_n    = f1_sec_q;
    present_cls = 1'b0;

    case (state_q)
      REQ:       if (imem_req && imem_gnt) state_n = WAIT;
      SPLIT_REQ: if (imem_req && imem_gnt) state_n = SPLIT_WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          buf_n       = imem_rdata;
          buf_word_n  = pc_q[31:2];
          buf_valid_n = 1'b1;
          present_cls = 1'b1;
          state_n     = HOLD;
        end
      end
      SPLIT_WAIT: begin
        if (imem_rvalid) begin
          buf_n       = imem_rdata;
          buf_word_n  = pc_q[31:2] + 30'd1;
          buf_valid_n = 1'b1;
          f1_instr_n  = imem_rdata;
          f1_pc_n     = pc_q;
          f1_valid_n  = 1'b1;
          f1_comp_n   = 1'b0;
          f1_sec_n    = 1'b0;
          split_n     = 1'b0;
          pc_n        = pc_q + 32'd4;
          state_n     = HOLD;
        end
      end
      HOLD: begin
        if (!stall_if) begin
          if (split_q) begin
            f1_valid_n = 1'b0;
            state_n    = SPLIT_REQ;
          end else if (buf_valid_q && buf_word_q == pc_q[31:2]) begin
            present_cls = 1'b1;
          end else begin
            f1_valid_n = 1'b0;
            state_n    = REQ;
          end
        end
      end
      default: state_n = REQ;
    endcase

    if (present_cls) begin
      f1_instr_n = src_word;
      f1_pc_n    = pc_q;
      f1_valid_n = 1'b1;
      f1_comp_n  = comp;
      f1_sec_n   = 1'b0;
      if (comp) pc_n = pc_q + 32'd2;
      else if (!pc_q[1]) pc_n = pc_q + 32'd4;
      else begin
        f1_sec_n = 1'b1;
        split_n  = 1'b1;
      end
    end

    // Redirect wins; a response still in flight must be swallowed before refetching.
    if (redirect) begin
      pc_n        = redirect_pc & ~32'd1;
      f1_valid_n  = 1'b0;
      buf_valid_n = 1'b0;
      split_n     = 1'b0;
      state_n     = REQ;
      kill_n      = (kill_q && !imem_rvalid) || (in_wait && !imem_rvalid) ||
                    (imem_req && imem_gnt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      buf_q       <= '0;
      buf_word_q  <= '0;
      buf_valid_q <= 1'b0;
      split_q     <= 1'b0;
      kill_q      <= 1'b0;
      run_q       <= 1'b0;
      f1_instr_q  <= '0;
      f1_pc_q     <= '0;
      f1_valid_q  <= 1'b0;
      f1_comp_q   <= 1'b0;
      f1_sec_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      buf_q       <= buf_n;
      buf_word_q  <= buf_word_n;
      buf_valid_q <= buf_valid_n;
      split_q     <= split_n;
      kill_q      <= kill_n;
      run_q       <= 1'b1;
      f1_instr_q  <= f1_instr_n;
      f1_pc_q     <= f1_pc_n;
      f1_valid_q  <= f1_valid_n;
      f1_comp_q   <= f1_comp_n;
      f1_sec_q    <= f1_sec_n;
      err_q       <= err_q | tmo_expired;
    end
  end

  assign fetch1_instruction    = f1_instr_q;
  assign fetch1_pc             = f1_pc_q;
  assign fetch1_valid          = f1_valid_q;
  assign is_compressed         = f1_comp_q;
  assign is_second_half_needed = f1_sec_q;
  assign pc_word_aligned       = f1_valid_q && !f1_pc_q[1];
  assign fetch_err             = err_q | tmo_expired;
endmodule
